// File: rtl/csa_pkg.sv
// Shared types and default widths for the carry-save accumulator controller.
package csa_pkg;

  localparam int CSA_W_DEF     = 4;
  localparam int CSA_ACC_W_DEF = 6;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCUM   = 2'd1,
    ST_RESOLVE = 2'd2,
    ST_DONE    = 2'd3
  } csa_state_t;

endpackage

// File: rtl/csa_row.sv
// One 3:2 carry-save compression row: bitwise sum and majority, purely combinational.
module csa_row #(
  parameter int N = 6
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [N-1:0] c,
  output logic [N-1:0] s,
  output logic [N-1:0] m
);

  assign s = a ^ b ^ c;
  assign m = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/csa_accum_ctrl.sv
// Carry-save accumulator with job sequencing and a single final carry-propagate add.
// Optional overflow flag and widened internal vectors enabled by CSA_ACCUM_OVF_EN.
//
// state   | meaning
// IDLE    | waiting for start; samples num_ops
// ACCUM   | accepting operands into the sum/carry vectors
// RESOLVE | one-cycle final add into the result register
// DONE    | result held until res_ready
module csa_accum_ctrl
  import csa_pkg::*;
#(
  parameter int W     = CSA_W_DEF,
  parameter int ACC_W = CSA_ACC_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       num_ops,
  input  logic             op_valid,
  input  logic [W-1:0]     op_data,
  output logic             op_ready,
  output logic             res_valid,
  output logic [ACC_W-1:0] res_data,
  input  logic             res_ready,
  output logic             busy
`ifdef CSA_ACCUM_OVF_EN
  ,output logic            ovf
`endif
);

`ifdef CSA_ACCUM_OVF_EN
  localparam int INT_W = ACC_W + 4;
`else
  localparam int INT_W = ACC_W;
`endif

  csa_state_t       state_q, state_d;
  logic [3:0]       rem_q, rem_d;
  logic [INT_W-1:0] sum_q, sum_d;
  logic [INT_W-1:0] carry_q, carry_d;
  logic [ACC_W-1:0] res_q, res_d;

  logic [INT_W-1:0] x_ext;
  logic [INT_W-1:0] c_shift;
  logic [INT_W-1:0] row_s;
  logic [INT_W-1:0] row_m;
  logic [INT_W-1:0] total;
  logic             accept;

  assign x_ext   = INT_W'(op_data);
  assign c_shift = carry_q << 1;
  assign total   = sum_q + c_shift;
  assign accept  = (state_q == ST_ACCUM) && op_valid;

  csa_row #(.N(INT_W)) u_row (
    .a (sum_q),
    .b (c_shift),
    .c (x_ext),
    .s (row_s),
    .m (row_m)
  );

`ifdef CSA_ACCUM_OVF_EN
  logic ovf_q, ovf_d;
`endif

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    res_d   = res_q;
`ifdef CSA_ACCUM_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          sum_d   = '0;
          carry_d = '0;
          rem_d   = num_ops;
          state_d = (num_ops == 4'd0) ? ST_RESOLVE : ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (accept) begin
          sum_d   = row_s;
          carry_d = row_m;
          rem_d   = rem_q - 4'd1;
          if (rem_q == 4'd1) state_d = ST_RESOLVE;
        end
      end
      ST_RESOLVE: begin
        res_d   = total[ACC_W-1:0];
`ifdef CSA_ACCUM_OVF_EN
        ovf_d   = |total[INT_W-1:ACC_W];
`endif
        state_d = ST_DONE;
      end
      ST_DONE: begin
        if (res_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
      sum_q   <= '0;
      carry_q <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      res_q   <= res_d;
    end
  end

`ifdef CSA_ACCUM_OVF_EN
  always_ff @(posedge clk) begin
    if (rst) ovf_q <= 1'b0;
    else     ovf_q <= ovf_d;
  end

  // Flag is only meaningful alongside a valid result.
  assign ovf = ovf_q && (state_q == ST_DONE);
`endif

  assign op_ready  = (state_q == ST_ACCUM);
  assign res_valid = (state_q == ST_DONE);
  assign res_data  = res_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_csa_accum_ctrl.sv
// Bench for csa_accum_ctrl: fixed vector table, hand sequences, randomized jobs vs. a sum model.
module tb_csa_accum_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] num_ops;
  logic       op_valid;
  logic [3:0] op_data;
  logic       op_ready;
  logic       res_valid;
  logic [5:0] res_data;
  logic       res_ready;
  logic       busy;
  logic       ovf_w;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  csa_accum_ctrl #(.W(4), .ACC_W(6)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .num_ops   (num_ops),
    .op_valid  (op_valid),
    .op_data   (op_data),
    .op_ready  (op_ready),
    .res_valid (res_valid),
    .res_data  (res_data),
    .res_ready (res_ready),
    .busy      (busy)
`ifdef CSA_ACCUM_OVF_EN
    ,.ovf      (ovf_w)
`endif
  );

`ifndef CSA_ACCUM_OVF_EN
  assign ovf_w = 1'b0;
`endif

  typedef struct {
    int          n;
    logic [63:0] ops;
    bit          gaps;
    int          hold;
    int          exp_res;
    bit          exp_ovf;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Runs one job from IDLE; checks handshake, latency, result hold and return to IDLE.
  task automatic do_job(input string tag, input int n, input logic [63:0] ops,
                        input bit gaps, input int hold, input bit poke_start,
                        output logic [5:0] res, output logic o);
    int i;
    int cyc;
    int wait_cyc;
    bool_acc: begin end
    start   = 1'b1;
    num_ops = 4'(n);
    tick();
    start   = 1'b0;
    i   = 0;
    cyc = 0;
    while (i < n && cyc < 200) begin
      op_valid = gaps ? ~cyc[0] : 1'b1;
      op_data  = ops[i*4 +: 4];
      start    = poke_start;
      num_ops  = 4'hf;
      if (op_valid && op_ready) i++;
      tick();
      cyc++;
    end
    start    = 1'b0;
    num_ops  = 4'd0;
    op_valid = 1'b0;
    if (i < n) check({tag, "_accept_timeout"}, i, n);
    check({tag, "_ready_after_last"}, int'(op_ready), 0);
    check({tag, "_valid_in_resolve"}, int'(res_valid), 0);
    tick();
    check({tag, "_valid_in_done"}, int'(res_valid), 1);
    wait_cyc = 0;
    while (!res_valid && wait_cyc < 10) begin
      tick();
      wait_cyc++;
    end
    res = res_data;
    o   = ovf_w;
    for (int h = 0; h < hold; h++) begin
      start   = poke_start;
      num_ops = 4'd2;
      tick();
      check({tag, "_hold_valid"}, int'(res_valid), 1);
      check({tag, "_hold_data"}, int'(res_data), int'(res));
      check({tag, "_hold_ovf"}, int'(ovf_w), int'(o));
    end
    start     = 1'b0;
    num_ops   = 4'd0;
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check({tag, "_valid_cleared"}, int'(res_valid), 0);
    check({tag, "_busy_cleared"}, int'(busy), 0);
  endtask

  vec_t        vecs[5];
  logic [5:0]  r;
  logic        o;
  logic [63:0] rops;
  int          rn;
  int          total;

  initial begin
    rst = 1'b1; start = 1'b0; num_ops = '0; op_valid = 1'b0;
    op_data = '0; res_ready = 1'b0;

    vecs[0] = '{3,  64'h0000_0000_0000_0975, 1'b0, 0, 21, 1'b0};
    vecs[1] = '{4,  64'h0000_0000_0000_4321, 1'b1, 0, 10, 1'b0};
    vecs[2] = '{15, 64'h0FFF_FFFF_FFFF_FFFF, 1'b0, 1, 33, 1'b1};
    vecs[3] = '{0,  64'h0,                   1'b0, 5, 0,  1'b0};
    vecs[4] = '{1,  64'h0000_0000_0000_0006, 1'b0, 0, 6,  1'b0};

    tick(); tick(); tick();
    rst = 1'b0;
    check("rst_op_ready", int'(op_ready), 0);
    check("rst_res_valid", int'(res_valid), 0);
    check("rst_res_data", int'(res_data), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_ovf", int'(ovf_w), 0);

    for (int v = 0; v < 5; v++) begin
      do_job($sformatf("vec%0d", v), vecs[v].n, vecs[v].ops, vecs[v].gaps,
             vecs[v].hold, 1'b0, r, o);
      check($sformatf("vec%0d_res", v), int'(r), vecs[v].exp_res);
`ifdef CSA_ACCUM_OVF_EN
      check($sformatf("vec%0d_ovf", v), int'(o), int'(vecs[v].exp_ovf));
`endif
    end

    // Abort mid-job: two of three operands taken, then reset.
    start = 1'b1; num_ops = 4'd3; tick(); start = 1'b0;
    op_valid = 1'b1; op_data = 4'd5; tick();
    op_data = 4'd7; tick();
    op_valid = 1'b0; rst = 1'b1; tick(); rst = 1'b0;
    check("abort_busy", int'(busy), 0);
    check("abort_op_ready", int'(op_ready), 0);
    do_job("after_abort", 1, 64'h6, 1'b0, 0, 1'b0, r, o);
    check("after_abort_res", int'(r), 6);

    // start and a different num_ops poked throughout ACCUM and DONE.
    do_job("poke", 3, 64'h321, 1'b1, 3, 1'b1, r, o);
    check("poke_res", int'(r), 6);

    for (int k = 0; k < 25; k++) begin
      rn    = $urandom_range(0, 15);
      rops  = '0;
      total = 0;
      for (int j = 0; j < rn; j++) begin
        rops[j*4 +: 4] = 4'($urandom_range(0, 15));
        total += int'(rops[j*4 +: 4]);
      end
      do_job($sformatf("rnd%0d", k), rn, rops, 1'($urandom_range(0, 1)),
             $urandom_range(0, 3), 1'($urandom_range(0, 1)), r, o);
      check($sformatf("rnd%0d_res", k), int'(r), total % 64);
`ifdef CSA_ACCUM_OVF_EN
      check($sformatf("rnd%0d_ovf", k), int'(o), (total >= 64) ? 1 : 0);
`endif
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/csa_accum_ctrl.md
CSA_ACCUM_CTRL -- requirements
Module: csa_accum_ctrl

Interface
REQ-001 SHALL have parameter W, default 4, meaning operand width.
REQ-002 SHALL have parameter ACC_W, default 6, meaning result width.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port start  input  1  begin a new accumulation job (sampled in IDLE only).
REQ-006 SHALL have port num_ops  input  4  operand count for the job, sampled with start.
REQ-007 SHALL have port op_valid  input  1  operand present.
REQ-008 SHALL have port op_data  input  W  operand, unsigned.
REQ-009 SHALL have port op_ready  output  1  block accepts operand.
REQ-010 SHALL have port res_valid  output  1  result present.
REQ-011 SHALL have port res_data  output  ACC_W  final sum.
REQ-012 SHALL have port res_ready  input  1  consumer accepts result.
REQ-013 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-014 SHALL have port ovf  output  1  overflow flag, qualified by res_valid (present only with CSA_ACCUM_OVF_EN).

Function
REQ-015 SHALL implement FSM states IDLE, ACCUM, RESOLVE, DONE.
REQ-016 IDLE: start=1 with num_ops>0 SHALL latch num_ops into a remaining-count register, clear sum and carry vectors, and go to ACCUM.
REQ-017 IDLE: start=1 with num_ops=0 SHALL clear sum/carry and go directly to RESOLVE (result 0).
REQ-018 start SHALL be ignored in every state except IDLE.
REQ-019 ACCUM: op_ready SHALL be 1; an operand is accepted only on a cycle with op_valid=1 and op_ready=1.
REQ-020 On each accept: sum<=sum^C^X and carry<=maj(sum,C,X), with X = zero-extended op_data and C = carry shifted left one bit (LSB 0), truncated to the internal width; remaining count decrements by 1.
REQ-021 The accept that reduces the remaining count to 0 SHALL move the FSM to RESOLVE; op_valid=0 cycles SHALL hold all state.
REQ-022 RESOLVE: one cycle; SHALL register res_data = (sum + (carry<<1)) mod 2^ACC_W and go to DONE.
REQ-023 Latency: res_valid SHALL assert exactly 2 cycles after the rising edge that captured the final operand.
REQ-024 DONE: res_valid=1, with res_data (and ovf) stable, until a cycle with res_ready=1; then SHALL go to IDLE with res_valid=0 on the next cycle.
REQ-025 op_ready SHALL be 0 in IDLE, RESOLVE and DONE; res_valid SHALL be 0 outside DONE.

Reset
REQ-026 rst=1 SHALL force IDLE from any state (including mid-ACCUM) on the next edge, discarding the partial job.
REQ-027 After reset: op_ready=0, res_valid=0, res_data=0, busy=0, ovf=0, sum=carry=0, remaining count=0.

Configuration
REQ-028 Macro CSA_ACCUM_OVF_EN defined: internal sum/carry vectors SHALL be ACC_W+4 bits wide; ovf SHALL be 1 in DONE iff the full-precision total is >= 2^ACC_W; ovf SHALL hold 0 outside DONE.
REQ-029 Macro undefined: the ovf port SHALL be absent, internal vectors SHALL be ACC_W bits wide, and results SHALL wrap silently modulo 2^ACC_W.

Structure
REQ-030 Package csa_pkg SHALL hold the FSM state enum typedef and the default W/ACC_W constants.
REQ-031 The 3:2 compression row SHALL be a sub-module csa_row (parameterised width, purely combinational, bitwise sum/majority); FSM, counters and the final adder SHALL reside in csa_accum_ctrl.

Verification
REQ-032 start, num_ops=3, operands 5,7,9 back-to-back, res_ready=1 -> res_data=21, res_valid exactly 2 cycles after the edge capturing the 9, ovf=0.
REQ-033 num_ops=4, operands 1,2,3,4 with op_valid low on alternate cycles -> exactly 4 accepts, res_data=10.
REQ-034 (CSA_ACCUM_OVF_EN defined) num_ops=15, all operands 15 -> res_data=33 (225 mod 64), ovf=1.
REQ-035 num_ops=0 with start -> res_valid 2 cycles later, res_data=0; res_ready held low 5 cycles -> res_valid and res_data stable throughout.
REQ-036 rst pulsed after 2 of 3 operands, then new job num_ops=1 with operand 6 -> res_data=6, no residue from the aborted job.
REQ-037 start pulsed during ACCUM and during DONE -> no effect on count, res_data or state.
